// File: rtl/io16_pkg.sv
// Shared constants, FSM encoding and transaction record for the 4-requester, 16-bit word write arbiter.
// Constants only: no latency and no backpressure of its own.
package io16_pkg;
   localparam int N_REQ  = 4;
   localparam int WORD_W = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_ACK   = 2'd2;

   // One granted write, captured in IDLE and replayed from here so late REQ changes cannot disturb it.
   typedef struct packed {
      logic [1:0]        id;
      logic [1:0]        addr;
      logic [WORD_W-1:0] dat;
   } wr_txn_t;
endpackage

// File: rtl/io16_rr_select.sv
// Combinational winner select: round-robin from ptr, or fixed priority with requester 0 highest.
// Zero latency; no backpressure (the caller samples the result only when it can accept a grant).
module io16_rr_select
   import io16_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [1:0]       ptr,
   input  logic             prio_mode,
   output logic [1:0]       gnt_id,
   output logic             gnt_vld
);

   logic [1:0] idx;

   // Scan from the farthest candidate down so the nearest asserted request is written last and wins.
   always_comb begin
      gnt_id  = 2'd0;
      gnt_vld = |req;
      idx     = 2'd0;
      for (int off = N_REQ - 1; off >= 0; off--) begin
         if (prio_mode) idx = off[1:0];
         else           idx = ptr + off[1:0];
         if (req[idx]) gnt_id = idx;
      end
   end

endmodule

// File: rtl/io16_write_arbiter.sv
// Arbitrates four 16-bit write requesters onto four registered output words, one write per 3 cycles.
// Grant latched 1 edge after REQ, write + ACK on the next edge; requesters hold REQ until their ACK.
module io16_write_arbiter
   import io16_pkg::*;
#(
   parameter int PRIO_MODE = 0
)
(
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic [N_REQ-1:0]        REQ,
   input  logic [2*N_REQ-1:0]      REQ_ADDR,
   input  logic [WORD_W*N_REQ-1:0] REQ_DATA,
   output logic [N_REQ-1:0]        ACK,
   output logic [1:0]              GNT_ID,
   output logic                    BUSY,
   output logic [N_REQ-1:0]        WR_STROBE,
   output logic [WORD_W-1:0]       OUT16BIT1,
   output logic [WORD_W-1:0]       OUT16BIT2,
   output logic [WORD_W-1:0]       OUT16BIT3,
   output logic [WORD_W-1:0]       OUT16BIT4
);

   logic [1:0]                    state_q;
   logic [1:0]                    ptr_q;
   wr_txn_t                       txn_q;
   wr_txn_t                       sel_txn;
   logic [N_REQ-1:0][WORD_W-1:0]  word_q;
   logic [N_REQ-1:0][1:0]         addr_arr;
   logic [N_REQ-1:0][WORD_W-1:0]  data_arr;
   logic [N_REQ-1:0]              ack_q;
   logic [N_REQ-1:0]              strobe_q;
   logic [1:0]                    sel_id;
   logic                          sel_vld;

   assign addr_arr = REQ_ADDR;
   assign data_arr = REQ_DATA;

   io16_rr_select u_select (
      .req       (REQ),
      .ptr       (ptr_q),
      .prio_mode (PRIO_MODE != 0),
      .gnt_id    (sel_id),
      .gnt_vld   (sel_vld)
   );

   always_comb begin
      sel_txn.id   = sel_id;
      sel_txn.addr = addr_arr[sel_id];
      sel_txn.dat  = data_arr[sel_id];
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         ptr_q    <= 2'd0;
         txn_q    <= '0;
         word_q   <= '0;
         ack_q    <= '0;
         strobe_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               ack_q    <= '0;
               strobe_q <= '0;
               if (sel_vld) begin
                  txn_q   <= sel_txn;
                  state_q <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               word_q[txn_q.addr] <= txn_q.dat;
               strobe_q           <= 4'b0001 << txn_q.addr;
               ack_q              <= 4'b0001 << txn_q.id;
               state_q            <= ST_ACK;
            end
            ST_ACK: begin
               ack_q    <= '0;
               strobe_q <= '0;
               state_q  <= ST_IDLE;
               // Pointer moves only once the transaction retires, so the next IDLE search starts past the winner.
               if (PRIO_MODE == 0) ptr_q <= txn_q.id + 2'd1;
            end
            default: begin
               ack_q    <= '0;
               strobe_q <= '0;
               state_q  <= ST_IDLE;
            end
         endcase
      end
   end

   assign ACK       = ack_q;
   assign WR_STROBE = strobe_q;
   assign BUSY      = (state_q != ST_IDLE);
   assign GNT_ID    = txn_q.id;
   assign OUT16BIT1 = word_q[0];
   assign OUT16BIT2 = word_q[1];
   assign OUT16BIT3 = word_q[2];
   assign OUT16BIT4 = word_q[3];

endmodule

// File: tb/tb_io16_write_arbiter.sv
// Scoreboard bench: one round-robin and one fixed-priority arbiter driven by directed vectors.
module tb_io16_write_arbiter;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        RST_N;
   logic [3:0]  req0, req1;
   logic [7:0]  addr0, addr1;
   logic [63:0] data0, data1;
   logic [3:0]  ack0, ack1, stb0, stb1;
   logic [1:0]  gnt0, gnt1;
   logic        busy0, busy1;
   logic [15:0] o0_1, o0_2, o0_3, o0_4, o1_1, o1_2, o1_3, o1_4;
   logic [63:0] img0, img1;

   assign img0 = {o0_4, o0_3, o0_2, o0_1};
   assign img1 = {o1_4, o1_3, o1_2, o1_1};

   io16_write_arbiter #(.PRIO_MODE(0)) u_rr (
      .CLK(CLK), .RST_N(RST_N), .REQ(req0), .REQ_ADDR(addr0), .REQ_DATA(data0),
      .ACK(ack0), .GNT_ID(gnt0), .BUSY(busy0), .WR_STROBE(stb0),
      .OUT16BIT1(o0_1), .OUT16BIT2(o0_2), .OUT16BIT3(o0_3), .OUT16BIT4(o0_4)
   );

   io16_write_arbiter #(.PRIO_MODE(1)) u_fp (
      .CLK(CLK), .RST_N(RST_N), .REQ(req1), .REQ_ADDR(addr1), .REQ_DATA(data1),
      .ACK(ack1), .GNT_ID(gnt1), .BUSY(busy1), .WR_STROBE(stb1),
      .OUT16BIT1(o1_1), .OUT16BIT2(o1_2), .OUT16BIT3(o1_3), .OUT16BIT4(o1_4)
   );

   typedef struct {
      logic [3:0]  ack;
      logic [3:0]  stb;
      logic [1:0]  gnt;
      logic [63:0] words;
   } exp_t;

   exp_t        q0[$], q1[$];
   logic [63:0] mdl0, mdl1;
   int          tests = 0;
   int          fails = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Expected write: requester id writes dat into word addr; model image tracks all four words.
   task automatic expect_wr(bit sel, int id, int addr, logic [15:0] dat);
      exp_t e;
      e.ack = 4'b0001 << id;
      e.stb = 4'b0001 << addr;
      e.gnt = id[1:0];
      if (sel) begin
         mdl1[16*addr +: 16] = dat;
         e.words = mdl1;
         q1.push_back(e);
      end else begin
         mdl0[16*addr +: 16] = dat;
         e.words = mdl0;
         q0.push_back(e);
      end
   endtask

   task automatic mon(bit sel);
      exp_t        e;
      logic [3:0]  a, s;
      logic [1:0]  g;
      logic        b;
      logic [63:0] w;
      string       pfx;
      a   = sel ? ack1 : ack0;
      s   = sel ? stb1 : stb0;
      g   = sel ? gnt1 : gnt0;
      b   = sel ? busy1 : busy0;
      w   = sel ? img1 : img0;
      pfx = sel ? "fp" : "rr";
      if (a != 4'b0000) begin
         if ((sel ? q1.size() : q0.size()) == 0) begin
            chk({pfx, "_unexpected_ack"}, {60'b0, a}, 64'b0);
         end else begin
            if (sel) e = q1.pop_front();
            else     e = q0.pop_front();
            chk({pfx, "_ack"},    {60'b0, a}, {60'b0, e.ack});
            chk({pfx, "_strobe"}, {60'b0, s}, {60'b0, e.stb});
            chk({pfx, "_gnt_id"}, {62'b0, g}, {62'b0, e.gnt});
            chk({pfx, "_busy"},   {63'b0, b}, 64'd1);
            chk({pfx, "_words"},  w, e.words);
         end
      end
   endtask

   always @(negedge CLK) begin
      mon(1'b0);
      mon(1'b1);
   end

   // Wait for n ACK pulses on one instance, dropping REQ bits in drop as they are acknowledged.
   task automatic serve(bit sel, int n, logic [3:0] drop);
      int got;
      got = 0;
      for (int cyc = 0; cyc < 20 * n && got < n; cyc++) begin
         logic [3:0] a;
         @(negedge CLK);
         a = sel ? ack1 : ack0;
         if (a != 4'b0000) begin
            got++;
            if (sel) req1 = req1 & ~(a & drop);
            else     req0 = req0 & ~(a & drop);
         end
      end
      chk(sel ? "fp_ack_count" : "rr_ack_count", got, n);
   endtask

   task automatic check_zero(string nm);
      chk({nm, "_rr_words"}, img0, 64'b0);
      chk({nm, "_rr_ctl"},   {55'b0, ack0, stb0, gnt0, busy0}, 64'b0);
      chk({nm, "_fp_words"}, img1, 64'b0);
      chk({nm, "_fp_ctl"},   {55'b0, ack1, stb1, gnt1, busy1}, 64'b0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST_N = 1'b0;
      req0  = '0;
      req1  = '0;
      repeat (2) @(negedge CLK);
      check_zero("reset_idle");
      mdl0  = '0;
      mdl1  = '0;
      RST_N = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      RST_N = 1'b0;
      req0 = '0; req1 = '0; addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
      mdl0 = '0; mdl1 = '0;
      repeat (3) @(negedge CLK);
      check_zero("reset");
      RST_N = 1'b1;

      // Single request: requester 0 writes 0xBEEF to word 2.
      expect_wr(0, 0, 2, 16'hBEEF);
      addr0 = 8'h02; data0 = 64'h0000_0000_0000_BEEF; req0 = 4'b0001;
      @(negedge CLK);
      chk("single_busy_gnt", {61'b0, busy0, gnt0}, {61'b0, 1'b1, 2'd0});
      chk("single_no_write_yet", {40'b0, ack0, stb0, o0_3}, 64'b0);
      serve(0, 1, 4'hF);
      @(negedge CLK);
      chk("single_pulse_end", {55'b0, ack0, stb0, busy0, 2'b0}, 64'b0);
      chk("single_word_held", {48'b0, o0_3}, 64'h0000_0000_0000_BEEF);

      // Round-robin from P=0, then wrap from 3 back to 0.
      do_reset();
      expect_wr(0, 0, 0, 16'h1111);
      expect_wr(0, 1, 1, 16'h2222);
      expect_wr(0, 2, 2, 16'h3333);
      expect_wr(0, 3, 3, 16'h4444);
      addr0 = 8'hE4; data0 = 64'h4444_3333_2222_1111; req0 = 4'hF;
      serve(0, 4, 4'hF);
      expect_wr(0, 0, 0, 16'hA0A0);
      expect_wr(0, 3, 1, 16'hD3D3);
      addr0 = 8'h40; data0 = 64'hD3D3_0000_0000_A0A0; req0 = 4'b1001;
      serve(0, 2, 4'hF);

      // Requester 2 drops REQ and scrambles its inputs while in WRITE.
      @(negedge CLK);
      expect_wr(0, 2, 3, 16'h1234);
      addr0 = 8'h30; data0 = 64'h0000_1234_0000_0000; req0 = 4'b0100;
      @(posedge CLK);
      #2;
      req0 = '0; addr0 = 8'h00; data0 = 64'hFFFF_FFFF_FFFF_FFFF;
      serve(0, 1, 4'hF);

      // Two requesters on the same word: the later grant wins.
      @(negedge CLK);
      expect_wr(0, 0, 0, 16'h0001);
      expect_wr(0, 1, 0, 16'h0002);
      addr0 = 8'h00; data0 = 64'h0000_0000_0002_0001; req0 = 4'b0011;
      serve(0, 2, 4'hF);
      @(negedge CLK);
      chk("same_word_last", {48'b0, o0_1}, 64'h0000_0000_0000_0002);

      // Reset while in WRITE: no write, no ACK, pointer back to 0.
      @(negedge CLK);
      addr0 = 8'h00; data0 = 64'h5555_0000_0000_0000; req0 = 4'b1000;
      @(posedge CLK);
      #2;
      RST_N = 1'b0; req0 = '0;
      repeat (2) @(negedge CLK);
      check_zero("reset_in_write");
      mdl0 = '0; mdl1 = '0;
      RST_N = 1'b1;
      @(negedge CLK);
      expect_wr(0, 1, 2, 16'h7171);
      expect_wr(0, 3, 3, 16'h7373);
      addr0 = 8'hC8; data0 = 64'h7373_0000_7171_0000; req0 = 4'b1010;
      serve(0, 2, 4'hF);

      // Fixed priority, REQ=1010 held: requester 1 twice, then 3 once 1 drops.
      @(negedge CLK);
      expect_wr(1, 1, 1, 16'hB1B1);
      expect_wr(1, 1, 1, 16'hB1B1);
      expect_wr(1, 3, 0, 16'hD3D3);
      addr1 = 8'h04; data1 = 64'hD3D3_0000_B1B1_0000; req1 = 4'b1010;
      serve(1, 2, 4'b0000);
      req1 = 4'b1000;
      serve(1, 1, 4'hF);

      repeat (3) @(negedge CLK);
      chk("rr_queue_drained", q0.size(), 0);
      chk("fp_queue_drained", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
